// File: rtl/complex_tree_pipe_pkg.sv
// Shared definitions for the pipelined AND/OR reduction tree: level count
// helper, per-level operator selection and width legality check.
package complex_tree_pipe_pkg;

    typedef enum logic {
        OP_AND = 1'b0,
        OP_OR  = 1'b1
    } op_e;

    // Number of halving levels needed to reduce a width-bit vector to one bit.
    function automatic int tree_levels(input int width);
        int levels;
        levels = 0;
        for (int w = width; w > 1; w = w >> 1) begin
            levels++;
        end
        return levels;
    endfunction

    // Odd levels OR their pairs, even levels AND them.
    function automatic op_e level_op(input int level);
        return (level % 2 == 1) ? OP_OR : OP_AND;
    endfunction

    function automatic bit width_is_legal(input int width);
        return (width >= 2) && (width <= 64) && ((width & (width - 1)) == 0);
    endfunction

endpackage

// File: rtl/complex_tree_pipe_tree_level.sv
// One registered reduction level: pairs bits 2j/2j+1 with a fixed operator
// and advances its data and valid bit only when the pipeline moves.
module tree_level
    import complex_tree_pipe_pkg::*;
#(
    parameter int  IN_W = 2,
    parameter op_e OP   = OP_OR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic [IN_W-1:0]   src_data,
    input  logic              src_valid,
    output logic [IN_W/2-1:0] res_data,
    output logic              res_valid
);

    localparam int OUT_W = IN_W / 2;

    logic [OUT_W-1:0] data_reg;
    logic [OUT_W-1:0] data_next;
    logic             valid_reg;

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_pair
            if (OP == OP_OR) begin : g_or
                assign data_next[gi] = src_data[2*gi] | src_data[2*gi+1];
            end else begin : g_and
                assign data_next[gi] = src_data[2*gi] & src_data[2*gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (advance) begin
            data_reg  <= data_next;
            valid_reg <= src_valid;
        end
    end

    assign res_data  = data_reg;
    assign res_valid = valid_reg;

endmodule

// File: rtl/complex_tree_pipe.sv
// Pipelined bitwise-AND followed by an alternating OR/AND reduction tree,
// with a single global stall and a saturating counter of z=1 results.
module complex_tree_pipe
    import complex_tree_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             z,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             hit_clr,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int L         = tree_levels(WIDTH);
    localparam int TREE_BITS = 2 * WIDTH - 1;

    generate
        if (!width_is_legal(WIDTH)) begin : g_bad_width
            $error("complex_tree_pipe: WIDTH must be a power of two in 2..64");
        end
    endgenerate

    // All levels packed back to back: level k occupies
    // [2*WIDTH - 2*(WIDTH>>k) +: WIDTH>>k], so the final bit is z.
    logic [TREE_BITS-1:0] tree;
    logic [L:0]           stage_valid;
    logic                 advance;

    logic [WIDTH-1:0]     p_reg;
    logic                 p_valid_reg;
    logic [CNT_W-1:0]     hit_cnt_reg;
    logic [CNT_W-1:0]     hit_cnt_next;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg       <= '0;
            p_valid_reg <= 1'b0;
        end else if (advance) begin
            p_reg       <= x & y;
            p_valid_reg <= in_valid;
        end
    end

    assign tree[WIDTH-1:0] = p_reg;
    assign stage_valid[0]  = p_valid_reg;

    generate
        for (genvar gi = 1; gi <= L; gi++) begin : g_level
            localparam int IN_W    = WIDTH >> (gi - 1);
            localparam int IN_OFF  = 2 * WIDTH - 2 * (WIDTH >> (gi - 1));
            localparam int OUT_OFF = 2 * WIDTH - 2 * (WIDTH >> gi);

            tree_level #(
                .IN_W (IN_W),
                .OP   (level_op(gi))
            ) u_level (
                .clk       (clk),
                .rst       (rst),
                .advance   (advance),
                .src_data  (tree[IN_OFF +: IN_W]),
                .src_valid (stage_valid[gi-1]),
                .res_data  (tree[OUT_OFF +: IN_W/2]),
                .res_valid (stage_valid[gi])
            );
        end
    endgenerate

    assign z         = tree[TREE_BITS-1];
    assign out_valid = stage_valid[L];

    always_comb begin
        hit_cnt_next = hit_cnt_reg;
        if (hit_clr) begin
            hit_cnt_next = '0;
        end else if (out_valid && out_ready && z && (hit_cnt_reg != {CNT_W{1'b1}})) begin
            hit_cnt_next = hit_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_reg <= '0;
        end else begin
            hit_cnt_reg <= hit_cnt_next;
        end
    end

    assign hit_cnt = hit_cnt_reg;

endmodule

// File: tb/tb_complex_tree_pipe.sv
// Scoreboard bench: stimulus pushes expected z values, per-instance monitors
// pop and compare on each output handshake.
module tb_complex_tree_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance a: WIDTH=8, CNT_W=16
    logic [7:0]  a_x, a_y;
    logic        a_in_valid, a_in_ready, a_z, a_out_valid, a_out_ready, a_hit_clr;
    logic [15:0] a_hit_cnt;
    // Instance b: WIDTH=2, CNT_W=2
    logic [1:0]  b_x, b_y;
    logic        b_in_valid, b_in_ready, b_z, b_out_valid, b_out_ready, b_hit_clr;
    logic [1:0]  b_hit_cnt;
    // Instance c: WIDTH=64, CNT_W=16
    logic [63:0] c_x, c_y;
    logic        c_in_valid, c_in_ready, c_z, c_out_valid, c_out_ready, c_hit_clr;
    logic [15:0] c_hit_cnt;

    complex_tree_pipe #(.WIDTH(8), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .x(a_x), .y(a_y), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .z(a_z), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .hit_clr(a_hit_clr), .hit_cnt(a_hit_cnt)
    );
    complex_tree_pipe #(.WIDTH(2), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .x(b_x), .y(b_y), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .z(b_z), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .hit_clr(b_hit_clr), .hit_cnt(b_hit_cnt)
    );
    complex_tree_pipe #(.WIDTH(64), .CNT_W(16)) u_dut_c (
        .clk(clk), .rst(rst), .x(c_x), .y(c_y), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .z(c_z), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .hit_clr(c_hit_clr), .hit_cnt(c_hit_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int c_hits   = 0;
    bit q_a[$];
    bit q_b[$];
    bit q_c[$];

    // Hand-computed stream: z = (p[1:0]!=0 & p[3:2]!=0) | (p[5:4]!=0 & p[7:6]!=0)
    logic [7:0] sx [10] = '{8'hFF, 8'h03, 8'h05, 8'h50, 8'h0F, 8'h81, 8'h3C, 8'hC3, 8'h66, 8'hAA};
    logic [7:0] sy [10] = '{8'hFF, 8'h01, 8'h05, 8'hF0, 8'hF0, 8'hFF, 8'h3C, 8'hC3, 8'h6F, 8'h55};
    bit         sz [10] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // Software model: AND, then halve repeatedly with OR on odd levels, AND on even.
    function automatic bit model(input logic [63:0] xv, input logic [63:0] yv, input int w);
        logic [63:0] p;
        logic [63:0] q;
        int n;
        int k;
        p = xv & yv;
        n = w;
        k = 1;
        while (n > 1) begin
            q = '0;
            for (int j = 0; j < n / 2; j++) begin
                q[j] = (k % 2 == 1) ? (p[2*j] | p[2*j+1]) : (p[2*j] & p[2*j+1]);
            end
            p = q;
            n = n / 2;
            k++;
        end
        return p[0];
    endfunction

    // Monitors: pop on output handshake, check hold behaviour while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_out_valid && a_out_ready) begin
                if (q_a.size() == 0) check("a_unexpected_out", a_out_valid, 0);
                else check("a_z", a_z, q_a.pop_front());
            end else if (a_out_valid && !a_out_ready) begin
                check("a_in_ready_stall", a_in_ready, 0);
                if (q_a.size() > 0) check("a_z_hold", a_z, q_a[0]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_out_valid && b_out_ready) begin
                if (q_b.size() == 0) check("b_unexpected_out", b_out_valid, 0);
                else check("b_z", b_z, q_b.pop_front());
            end else if (b_out_valid && !b_out_ready) begin
                check("b_in_ready_stall", b_in_ready, 0);
                if (q_b.size() > 0) check("b_z_hold", b_z, q_b[0]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (c_out_valid && c_out_ready) begin
                if (q_c.size() == 0) check("c_unexpected_out", c_out_valid, 0);
                else begin
                    if (q_c[0]) c_hits++;
                    check("c_z", c_z, q_c.pop_front());
                end
            end else if (c_out_valid && !c_out_ready) begin
                check("c_in_ready_stall", c_in_ready, 0);
                if (q_c.size() > 0) check("c_z_hold", c_z, q_c[0]);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the input handshake edge.
    task automatic a_send(input logic [7:0] xv, input logic [7:0] yv, input bit ez);
        int n;
        n = 0;
        a_x = xv;
        a_y = yv;
        a_in_valid = 1'b1;
        @(negedge clk);
        while (!a_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_ready) check("a_send_timeout", a_in_ready, 1);
        else q_a.push_back(ez);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic a_latency(input logic [7:0] xv, input logic [7:0] yv, input bit ez);
        int cnt;
        a_send(xv, yv, ez);
        cnt = 1;
        while (!a_out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("a_latency", cnt, 4);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", q_a.size() + q_b.size() + q_c.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_x = '0; a_y = '0; a_in_valid = 0; a_out_ready = 1; a_hit_clr = 0;
        b_x = '0; b_y = '0; b_in_valid = 0; b_out_ready = 1; b_hit_clr = 0;
        c_x = '0; c_y = '0; c_in_valid = 0; c_out_ready = 1; c_hit_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_z", a_z, 0);
        check("rst_a_hit_cnt", a_hit_cnt, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_c_out_valid", c_out_valid, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single all-ones vector: latency and one hit
        a_latency(8'hFF, 8'hFF, 1'b1);
        drain();
        check("a_hit_after_first", a_hit_cnt, 1);

        // Back-to-back results on consecutive cycles
        a_send(8'h03, 8'h01, 1'b0);
        a_send(8'h05, 8'h05, 1'b1);
        begin
            int n;
            n = 0;
            while (!a_out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("a_b2b_first_z", a_z, 0);
        @(posedge clk);
        #1;
        check("a_b2b_second_valid", a_out_valid, 1);
        check("a_b2b_second_z", a_z, 1);
        drain();
        check("a_hit_after_b2b", a_hit_cnt, 2);

        // Ten-input stream with a three-cycle consumer stall
        begin
            int sent;
            int cyc;
            sent = 0;
            cyc = 0;
            while (sent < 10 && cyc < 100) begin
                a_out_ready = !(cyc >= 6 && cyc < 9);
                a_x = sx[sent];
                a_y = sy[sent];
                a_in_valid = 1'b1;
                @(negedge clk);
                if (cyc >= 6 && cyc < 9) check("a_stall_out_valid", a_out_valid, 1);
                if (a_in_ready) begin
                    q_a.push_back(sz[sent]);
                    sent++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            a_in_valid = 1'b0;
            a_out_ready = 1'b1;
            check("a_stream_sent", sent, 10);
        end
        drain();
        check("a_hit_after_stream", a_hit_cnt, 6);

        // Reset with three results in flight
        a_send(8'hFF, 8'hFF, 1'b1);
        a_send(8'hFF, 8'hFF, 1'b1);
        a_send(8'hFF, 8'hFF, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_a.delete();
        check("a_rst_hit_cnt", a_hit_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            check("a_rst_out_valid", a_out_valid, 0);
            @(posedge clk);
            #1;
        end
        a_latency(8'hFF, 8'hFF, 1'b1);
        drain();
        check("a_hit_after_rst", a_hit_cnt, 1);
        a_hit_clr = 1'b1;
        @(posedge clk);
        #1;
        a_hit_clr = 1'b0;
        check("a_hit_clr", a_hit_cnt, 0);

        // CNT_W=2 saturation: x=3,y=1 gives z=1 at WIDTH=2
        begin
            int sent;
            int n;
            sent = 0;
            n = 0;
            b_x = 2'b11;
            b_y = 2'b01;
            b_in_valid = 1'b1;
            while (sent < 5 && n < 50) begin
                @(negedge clk);
                if (b_in_ready) begin
                    q_b.push_back(1'b1);
                    sent++;
                end
                @(posedge clk);
                #1;
                n++;
                b_in_valid = (sent < 5);
            end
            b_in_valid = 1'b0;
        end
        drain();
        check("b_hit_saturated", b_hit_cnt, 3);
        b_in_valid = 1'b1;
        @(negedge clk);
        if (b_in_ready) q_b.push_back(1'b1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (!b_out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("b_hit_pending_valid", b_out_valid, 1);
        b_hit_clr = 1'b1;
        @(posedge clk);
        #1;
        b_hit_clr = 1'b0;
        check("b_hit_clr_with_hit", b_hit_cnt, 0);
        drain();

        // Random vectors on WIDTH=2 and WIDTH=64 with random back-pressure
        begin
            int bi;
            int ci;
            int n;
            bit bh;
            bit ch;
            bi = 0;
            ci = 0;
            n = 0;
            b_x = 2'($urandom_range(0, 3));
            b_y = 2'($urandom_range(0, 3));
            c_x = {$urandom, $urandom};
            c_y = {$urandom, $urandom};
            b_in_valid = 1'b1;
            c_in_valid = 1'b1;
            while ((bi < 1000 || ci < 1000) && n < 5000) begin
                b_out_ready = ($urandom_range(0, 3) != 0);
                c_out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                bh = b_in_valid && b_in_ready;
                ch = c_in_valid && c_in_ready;
                if (bh) begin
                    q_b.push_back(model({62'b0, b_x}, {62'b0, b_y}, 2));
                    bi++;
                end
                if (ch) begin
                    q_c.push_back(model(c_x, c_y, 64));
                    ci++;
                end
                @(posedge clk);
                #1;
                n++;
                if (bh) begin
                    b_x = 2'($urandom_range(0, 3));
                    b_y = 2'($urandom_range(0, 3));
                    b_in_valid = (bi < 1000);
                end
                if (ch) begin
                    c_x = {$urandom, $urandom};
                    c_y = {$urandom, $urandom};
                    c_in_valid = (ci < 1000);
                end
            end
            b_in_valid = 1'b0;
            c_in_valid = 1'b0;
            b_out_ready = 1'b1;
            c_out_ready = 1'b1;
            check("rand_vectors_sent", bi + ci, 2000);
        end
        drain();
        @(posedge clk);
        #1;
        check("c_hit_cnt_total", c_hit_cnt, c_hits);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/complex_tree_pipe.md
COMPLEX_TREE_PIPE -- requirements
Module: complex_tree_pipe

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width (power of two, 2..64).
REQ-002 Parameter CNT_W, default 16, SHALL set the hit-counter width.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port x  input  WIDTH  SHALL be operand A.
REQ-006 Port y  input  WIDTH  SHALL be operand B.
REQ-007 Port in_valid  input  1  SHALL qualify x/y.
REQ-008 Port in_ready  output  1  SHALL indicate that x/y will be accepted this cycle.
REQ-009 Port z  output  1  SHALL be the reduction result.
REQ-010 Port out_valid  output  1  SHALL qualify z.
REQ-011 Port out_ready  input  1  SHALL indicate that the consumer takes z this cycle.
REQ-012 Port hit_clr  input  1  SHALL clear the hit counter.
REQ-013 Port hit_cnt  output  CNT_W  SHALL count accepted results with z=1.

Function
REQ-014 Level 0 SHALL compute p[i] = x[i] & y[i] for every bit.
REQ-015 Reduction levels k = 1..L, with L = log2(WIDTH), SHALL each halve the vector by pairing bits 2j and 2j+1: OR for odd k, AND for even k.
REQ-016 Level 0 and each reduction level SHALL be registered, giving L+1 register stages; z is the single bit of the last stage.
REQ-017 Latency SHALL be exactly L+1 cycles from an input handshake to out_valid with no stall (4 cycles at WIDTH=8).
REQ-018 Each stage SHALL carry a valid bit; advance = !out_valid | out_ready; all stages and valid bits update only when advance=1.
REQ-019 in_ready SHALL equal advance (combinational); a handshake is in_valid & in_ready.
REQ-020 When advance=1 and there is no handshake, a bubble (valid=0) SHALL enter stage 0.
REQ-021 Throughput SHALL be one result per cycle while out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, z, out_valid and all stage contents SHALL hold unchanged.
REQ-023 An output handshake (out_valid & out_ready) with z=1 SHALL increment hit_cnt by 1, saturating at 2^CNT_W-1.
REQ-024 hit_clr=1 SHALL set hit_cnt to 0 next cycle and SHALL override a simultaneous increment.
REQ-025 Data in stages whose valid bit is 0 SHALL NOT affect z qualification or hit_cnt.

Reset
REQ-026 rst=1 SHALL clear all stage valid bits, z, out_valid and hit_cnt to 0 on the next clock edge.
REQ-027 Reset mid-operation SHALL discard all in-flight results with no output handshake; rst SHALL override hit_clr and advance.
REQ-028 in_ready SHALL be 1 during and after reset, because out_valid=0.

Structure
REQ-029 The shared package SHALL hold the function computing L = log2(WIDTH) and the per-level operator enum (OP_AND, OP_OR).
REQ-030 One sub-module, tree_level, SHALL implement one registered reduction level, parametrised by input width and operator, with data/valid/advance ports; the top SHALL instantiate it L times from a generate loop.
REQ-031 Elaboration SHALL fail if WIDTH is not a power of two in 2..64.

Verification
REQ-032 WIDTH=8, x=0xFF, y=0xFF, out_ready=1 -> z=1, out_valid rises exactly 4 cycles after the handshake, hit_cnt=1.
REQ-033 x=0x03, y=0x01 -> z=0; then x=0x05, y=0x05 -> z=1; the back-to-back results appear on consecutive cycles.
REQ-034 Stream of 10 inputs with out_ready held 0 from cycle 6 for 3 cycles -> in_ready=0 during the stall, z held, no result lost or duplicated, order preserved.
REQ-035 rst pulsed with 3 results in flight -> out_valid stays 0 afterwards, hit_cnt=0, and the next input emerges after 4 cycles.
REQ-036 CNT_W=2, 5 hits -> hit_cnt saturates at 3; hit_clr asserted together with a hit -> hit_cnt=0.
REQ-037 WIDTH=2 and WIDTH=64 random vectors compared against a software model of the AND/OR tree -> zero mismatches over 1000 vectors.
